// File: rtl/hazard_ctrl.sv
// Pipeline hazard/hold controller with a single-entry divide scoreboard; hold/flush are
// combinational from inputs plus registered scoreboard state. Define HAZARD_LOAD_USE_EN for load-use bubbles.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_reg1_raddr_i,
    input  logic [REG_AW-1:0] id_reg2_raddr_i,
    input  logic              id_reg_we_i,
    input  logic [REG_AW-1:0] id_reg_waddr_i,
    input  logic              id_is_div_i,
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] ex_load_rd_i,
    input  logic              ex_div_start_i,
    input  logic [REG_AW-1:0] ex_div_rd_i,
    input  logic              div_ready_i,
    input  logic              ex_jump_flag_i,
    input  logic              bus_hold_i,
    output logic [2:0]        hold_o,
    output logic              flush_o,
    output logic              div_busy_o,
    output logic [REG_AW-1:0] div_rd_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_WB   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [REG_AW-1:0] div_rd_q;
    logic              div_haz;
    logic              load_haz;

    function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The destination is captured even under a same-cycle jump: the divide is already in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_rd_q <= '0;
        end else if (state == IDLE && ex_div_start_i) begin
            div_rd_q <= ex_div_rd_i;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (ex_div_start_i) state_nxt = DIV_WAIT;
            DIV_WAIT: if (div_ready_i)    state_nxt = DIV_WB;
            DIV_WB:                       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

`ifdef HAZARD_LOAD_USE_EN
    assign load_haz = id_valid_i && ex_load_i &&
                      (match(id_reg1_raddr_i, ex_load_rd_i) || match(id_reg2_raddr_i, ex_load_rd_i));
`else
    logic unused_load;
    assign unused_load = ^{ex_load_i, ex_load_rd_i};
    assign load_haz    = 1'b0;
`endif

    always_comb begin
        div_busy_o = !rst && (state != IDLE);
        div_rd_o   = div_busy_o ? div_rd_q : '0;
        div_haz    = id_valid_i && (state != IDLE) &&
                     (match(id_reg1_raddr_i, div_rd_q) ||
                      match(id_reg2_raddr_i, div_rd_q) ||
                      (id_reg_we_i && match(id_reg_waddr_i, div_rd_q)) ||
                      id_is_div_i);
        hold_o     = 3'b000;
        flush_o    = 1'b0;
        if (rst) begin
            hold_o  = 3'b000;
            flush_o = 1'b0;
        end else if (ex_jump_flag_i) begin
            flush_o = 1'b1;
        end else if (bus_hold_i || div_haz || load_haz) begin
            hold_o  = 3'b111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (hold_o != 3'b000 && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run
// against a queue-based scoreboard model; a 4-bit counter instance covers saturation.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_we, id_is_div;
    logic       ex_load;
    logic [4:0] ex_load_rd;
    logic       ex_div_start;
    logic [4:0] ex_div_rd;
    logic       div_ready, ex_jump, bus_hold;

    logic [2:0]  hold;
    logic        flush, div_busy;
    logic [4:0]  div_rd;
    logic [31:0] stall_cnt;

    logic [2:0]  s_hold;
    logic        s_flush, s_busy;
    logic [4:0]  s_rd;
    logic [3:0]  s_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl #(.REG_AW(5), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid),
        .id_reg1_raddr_i(id_rs1), .id_reg2_raddr_i(id_rs2),
        .id_reg_we_i(id_we), .id_reg_waddr_i(id_rd), .id_is_div_i(id_is_div),
        .ex_load_i(ex_load), .ex_load_rd_i(ex_load_rd),
        .ex_div_start_i(ex_div_start), .ex_div_rd_i(ex_div_rd),
        .div_ready_i(div_ready), .ex_jump_flag_i(ex_jump), .bus_hold_i(bus_hold),
        .hold_o(hold), .flush_o(flush), .div_busy_o(div_busy),
        .div_rd_o(div_rd), .stall_cnt_o(stall_cnt)
    );

    hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid_i(id_valid),
        .id_reg1_raddr_i(id_rs1), .id_reg2_raddr_i(id_rs2),
        .id_reg_we_i(id_we), .id_reg_waddr_i(id_rd), .id_is_div_i(id_is_div),
        .ex_load_i(ex_load), .ex_load_rd_i(ex_load_rd),
        .ex_div_start_i(ex_div_start), .ex_div_rd_i(ex_div_rd),
        .div_ready_i(div_ready), .ex_jump_flag_i(ex_jump), .bus_hold_i(bus_hold),
        .hold_o(s_hold), .flush_o(s_flush), .div_busy_o(s_busy),
        .div_rd_o(s_rd), .stall_cnt_o(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

`ifdef HAZARD_LOAD_USE_EN
    localparam bit LOAD_USE = 1'b1;
`else
    localparam bit LOAD_USE = 1'b0;
`endif

    task automatic clear_inputs();
        rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_we = 0;
        id_is_div = 0; ex_load = 0; ex_load_rd = 0; ex_div_start = 0; ex_div_rd = 0;
        div_ready = 0; ex_jump = 0; bus_hold = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        next();
        next();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            ex_jump = 1'(i == 1); bus_hold = 1'(i != 1); id_valid = 1; id_is_div = 1;
            @(negedge clk);
            n_checks++; if ({hold, flush} !== 4'b0) $display("FAIL reset_hold_flush: got %b/%b need 000/0", hold, flush); else n_pass++;
            n_checks++; if ({div_busy, div_rd} !== 6'b0) $display("FAIL reset_busy_rd: got %b/%0d need 0/0", div_busy, div_rd); else n_pass++;
            next();
        end
        clear_inputs();
        @(negedge clk);
        n_checks++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d need 0", stall_cnt); else n_pass++;
        n_checks++; if (s_cnt !== 4'd0) $display("FAIL reset_sat_cnt: got %0d need 0", s_cnt); else n_pass++;
        next();
    endtask

    task automatic test_div_dependency();
        do_reset();
        ex_div_start = 1; ex_div_rd = 5;
        @(negedge clk);
        n_checks++; if (hold !== 3'b000) $display("FAIL div_issue_hold: got %b need 000", hold); else n_pass++;
        next();
        ex_div_start = 0; id_valid = 1; id_rs1 = 5;
        for (int i = 1; i <= 11; i++) begin
            div_ready = 1'(i == 10);
            @(negedge clk);
            n_checks++; if (hold !== 3'b111) $display("FAIL div_dep_hold c%0d: got %b need 111", i, hold); else n_pass++;
            next();
        end
        div_ready = 0;
        @(negedge clk);
        n_checks++; if (hold !== 3'b000) $display("FAIL div_dep_release: got %b need 000", hold); else n_pass++;
        n_checks++; if (stall_cnt !== 32'd11) $display("FAIL div_dep_cnt: got %0d need 11", stall_cnt); else n_pass++;
        n_checks++; if (div_busy !== 1'b0) $display("FAIL div_dep_idle: got %b need 0", div_busy); else n_pass++;
        next();
        clear_inputs();
    endtask

    task automatic test_independent_and_second_div();
        logic [2:0] exp_h [6] = '{3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b111};
        clear_inputs();
        ex_div_start = 1; ex_div_rd = 5;
        next();
        ex_div_start = 0;
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            id_valid = 1;
            case (i)
                0: id_rs1 = 6;
                1: begin id_rs1 = 6; id_we = 1; id_rd = 5; end
                2: begin id_we = 0; id_rd = 5; end
                default: id_is_div = 1;
            endcase
            div_ready = 1'(i == 4);
            @(negedge clk);
            n_checks++; if (hold !== exp_h[i]) $display("FAIL indep_div c%0d: got %b need %b", i, hold, exp_h[i]); else n_pass++;
            if (i == 0) begin
                n_checks++; if ({div_busy, div_rd} !== {1'b1, 5'd5}) $display("FAIL indep_busy_rd: got %b/%0d need 1/5", div_busy, div_rd); else n_pass++;
            end
            next();
        end
        clear_inputs();
        id_valid = 1; id_is_div = 1;
        @(negedge clk);
        n_checks++; if (hold !== 3'b000) $display("FAIL second_div_release: got %b need 000", hold); else n_pass++;
        next();
        clear_inputs();
    endtask

    task automatic test_x0_and_load_use();
        clear_inputs();
        ex_div_start = 1; ex_div_rd = 0;
        next();
        clear_inputs();
        id_valid = 1; id_we = 1;
        @(negedge clk);
        n_checks++; if ({div_busy, div_rd, hold} !== {1'b1, 5'd0, 3'b000}) $display("FAIL x0_div: got busy %b rd %0d hold %b need 1/0/000", div_busy, div_rd, hold); else n_pass++;
        div_ready = 1;
        next();
        div_ready = 0;
        next();
        clear_inputs();
        ex_load = 1; ex_load_rd = 3; id_valid = 1; id_rs2 = 3;
        @(negedge clk);
        n_checks++; if (hold !== (LOAD_USE ? 3'b111 : 3'b000)) $display("FAIL load_use: got %b need %b", hold, LOAD_USE ? 3'b111 : 3'b000); else n_pass++;
        next();
        ex_load = 0;
        @(negedge clk);
        n_checks++; if (hold !== 3'b000) $display("FAIL load_use_release: got %b need 000", hold); else n_pass++;
        next();
        ex_load = 1; ex_load_rd = 0; id_rs2 = 0; id_rs1 = 0;
        @(negedge clk);
        n_checks++; if (hold !== 3'b000) $display("FAIL load_x0: got %b need 000", hold); else n_pass++;
        next();
        clear_inputs();
    endtask

    task automatic test_priority();
        clear_inputs();
        ex_div_start = 1; ex_div_rd = 7;
        next();
        clear_inputs();
        ex_jump = 1; bus_hold = 1; id_valid = 1; id_rs1 = 7;
        @(negedge clk);
        n_checks++; if ({flush, hold} !== 4'b1000) $display("FAIL prio_jump: got %b/%b need 1/000", flush, hold); else n_pass++;
        next();
        clear_inputs();
        bus_hold = 1;
        @(negedge clk);
        n_checks++; if ({flush, hold} !== 4'b0111) $display("FAIL prio_bus: got %b/%b need 0/111", flush, hold); else n_pass++;
        n_checks++; if (div_busy !== 1'b1) $display("FAIL jump_keeps_div: got %b need 1", div_busy); else n_pass++;
        next();
        clear_inputs(); div_ready = 1;
        next();
        clear_inputs();
        next();
        ex_div_start = 1; ex_div_rd = 9; ex_jump = 1;
        @(negedge clk);
        n_checks++; if ({flush, hold} !== 4'b1000) $display("FAIL start_jump_flush: got %b/%b need 1/000", flush, hold); else n_pass++;
        next();
        clear_inputs();
        @(negedge clk);
        n_checks++; if ({div_busy, div_rd} !== {1'b1, 5'd9}) $display("FAIL start_jump_latch: got %b/%0d need 1/9", div_busy, div_rd); else n_pass++;
        div_ready = 1;
        next();
        clear_inputs();
        next();
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        ex_div_start = 1; ex_div_rd = 4;
        next();
        clear_inputs(); bus_hold = 1;
        next();
        clear_inputs(); rst = 1;
        @(negedge clk);
        n_checks++; if ({div_busy, hold} !== 4'b0) $display("FAIL rst_mid_during: got %b/%b need 0/000", div_busy, hold); else n_pass++;
        next();
        clear_inputs();
        @(negedge clk);
        n_checks++; if ({div_busy, div_rd} !== 6'b0) $display("FAIL rst_mid_after: got %b/%0d need 0/0", div_busy, div_rd); else n_pass++;
        div_ready = 1; id_valid = 1; id_rs1 = 4; id_is_div = 1;
        next();
        div_ready = 0;
        @(negedge clk);
        n_checks++; if ({div_busy, hold} !== 4'b0) $display("FAIL stray_ready: got %b/%b need 0/000", div_busy, hold); else n_pass++;
        n_checks++; if (stall_cnt !== 32'd0) $display("FAIL stray_cnt: got %0d need 0", stall_cnt); else n_pass++;
        next();
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        bus_hold = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (s_cnt !== 4'((i > 15) ? 15 : i)) $display("FAIL sat_cnt c%0d: got %0d need %0d", i, s_cnt, (i > 15) ? 15 : i); else n_pass++;
            next();
        end
        clear_inputs();
        @(negedge clk);
        n_checks++; if (s_cnt !== 4'hF) $display("FAIL sat_final: got %0h need f", s_cnt); else n_pass++;
        n_checks++; if (stall_cnt !== 32'd20) $display("FAIL wide_cnt: got %0d need 20", stall_cnt); else n_pass++;
        next();
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 0);
    endfunction

    task automatic test_random();
        logic [4:0]  pend_q[$];
        bit          written;
        logic [31:0] m_cnt;
        bit          dhaz, lhaz;
        logic [2:0]  e_hold;
        logic        e_flush, e_busy;
        logic [4:0]  e_rd;
        int          errs = 0;
        do_reset();
        m_cnt = 0; written = 0;
        for (int c = 0; c < 400; c++) begin
            rst          = ($urandom_range(63) == 0);
            id_valid     = ($urandom_range(3) != 0);
            id_rs1       = 5'($urandom_range(7));
            id_rs2       = 5'($urandom_range(7));
            id_rd        = 5'($urandom_range(7));
            id_we        = 1'($urandom_range(1));
            id_is_div    = ($urandom_range(7) == 0);
            ex_load      = ($urandom_range(3) == 0);
            ex_load_rd   = 5'($urandom_range(7));
            ex_div_start = ($urandom_range(5) == 0);
            ex_div_rd    = 5'($urandom_range(7));
            div_ready    = ($urandom_range(3) == 0);
            ex_jump      = ($urandom_range(15) == 0);
            bus_hold     = ($urandom_range(15) == 0);
            dhaz = id_valid && pend_q.size() != 0 &&
                   (hit(id_rs1, pend_q[0]) || hit(id_rs2, pend_q[0]) ||
                    (id_we && hit(id_rd, pend_q[0])) || id_is_div);
            lhaz = LOAD_USE && id_valid && ex_load && (hit(id_rs1, ex_load_rd) || hit(id_rs2, ex_load_rd));
            e_flush = !rst && ex_jump;
            e_hold  = (!rst && !ex_jump && (bus_hold || dhaz || lhaz)) ? 3'b111 : 3'b000;
            e_busy  = !rst && pend_q.size() != 0;
            e_rd    = e_busy ? pend_q[0] : 5'd0;
            @(negedge clk);
            n_checks++;
            if ({hold, flush, div_busy, div_rd, stall_cnt} !== {e_hold, e_flush, e_busy, e_rd, m_cnt}) begin
                if (errs < 10) $display("FAIL random c%0d: got hold %b flush %b busy %b rd %0d cnt %0d need %b %b %b %0d %0d",
                                        c, hold, flush, div_busy, div_rd, stall_cnt, e_hold, e_flush, e_busy, e_rd, m_cnt);
                errs++;
            end else n_pass++;
            if (rst) begin
                pend_q.delete(); written = 0; m_cnt = 0;
            end else begin
                if (e_hold != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt++;
                if (pend_q.size() == 0) begin
                    if (ex_div_start) pend_q.push_back(ex_div_rd);
                end else if (written) begin
                    void'(pend_q.pop_front()); written = 0;
                end else if (div_ready) begin
                    written = 1;
                end
            end
            next();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_div_dependency();
        test_independent_and_second_div();
        test_x0_and_load_use();
        test_priority();
        test_reset_mid_div();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and hold controller for the three-stage core. It sits beside the decode stage and takes that stage's register read and write addresses, the EX-stage load and divider activity, the EX jump flag and the external bus hold. From these it produces per-stage hold/bubble controls and the pipeline flush. It owns the single-entry scoreboard for the multi-cycle divider, so decode can issue past a divide until a dependent or conflicting instruction arrives.

## Interface
Parameters:
- `REG_AW`, 5, register address width.
- `CNT_W`, 32, stall counter width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `id_valid_i`  in  1  decode holds a valid instruction.
- `id_reg1_raddr_i`  in  REG_AW  decode rs1 read address (0 = no read).
- `id_reg2_raddr_i`  in  REG_AW  decode rs2 read address (0 = no read).
- `id_reg_we_i`  in  1  decode instruction writes rd.
- `id_reg_waddr_i`  in  REG_AW  decode rd.
- `id_is_div_i`  in  1  decode holds DIV/DIVU/REM/REMU.
- `ex_load_i`  in  1  EX holds a load this cycle.
- `ex_load_rd_i`  in  REG_AW  destination of that load.
- `ex_div_start_i`  in  1  divider accepted an operation this cycle.
- `ex_div_rd_i`  in  REG_AW  destination of that divide.
- `div_ready_i`  in  1  divider result written to the register file this cycle.
- `ex_jump_flag_i`  in  1  EX redirects the PC this cycle.
- `bus_hold_i`  in  1  bus/debug requests a full freeze.
- `hold_o`  out  3  bit0 hold PC, bit1 hold IF/ID, bit2 insert NOP into ID/EX.
- `flush_o`  out  1  kill IF/ID and ID/EX contents.
- `div_busy_o`  out  1  scoreboard entry valid.
- `div_rd_o`  out  REG_AW  pending divide destination (0 when idle).
- `stall_cnt_o`  out  CNT_W  cycles with `hold_o != 0`, saturating.

## Operation
- Scoreboard FSM has three states: IDLE, DIV_WAIT, DIV_WB.
  - IDLE -> DIV_WAIT on `ex_div_start_i`; latch `ex_div_rd_i`.
  - DIV_WAIT -> DIV_WB on `div_ready_i`.
  - DIV_WB -> IDLE unconditionally after one cycle. The entry is still valid in DIV_WB, so dependents release the cycle after writeback.
  - `ex_div_start_i` outside IDLE is ignored. It cannot occur legally, because `div_haz` holds any second divide.
  - `div_ready_i` outside DIV_WAIT is ignored.
  - `ex_jump_flag_i` does not cancel a divide in flight.
- `div_busy_o` = state != IDLE. `div_rd_o` = latched rd while busy, else 0.
- Address matches ignore x0: `match(a, b) = (a == b) && (a != 0)`.
- `div_haz` = `id_valid_i` && busy && (match(rs1, div_rd) || match(rs2, div_rd) || (`id_reg_we_i` && match(rd, div_rd)) || `id_is_div_i`).
- `load_haz` = `id_valid_i` && `ex_load_i` && (match(rs1, load_rd) || match(rs2, load_rd)). It is active only with the macro below.
- Output priority, highest first:
  1. `ex_jump_flag_i`: `flush_o` = 1, `hold_o` = 3'b000. The PC takes the target and hazards on the killed instruction are dropped.
  2. `bus_hold_i`: `hold_o` = 3'b111, `flush_o` = 0.
  3. `div_haz` or `load_haz`: `hold_o` = 3'b111, which holds PC and IF/ID and bubbles EX.
  4. Otherwise `hold_o` = 3'b000, `flush_o` = 0.
- `stall_cnt_o` increments every cycle with `hold_o != 0` and saturates at all-ones.

## Timing
- `hold_o` and `flush_o` are combinational, same cycle as the inputs, from inputs plus registered scoreboard state. There is no registered output path.
- Scoreboard and counter update on the `clk` rising edge.
- Divide stall release: if `div_ready_i` is high in cycle N, dependents hold through N+1 and issue in N+2.
- Load-use stall is exactly 1 cycle per load, because the load leaves EX next cycle.
- Reset: while `rst` = 1, all outputs are 0 (`hold_o` = 0, `flush_o` = 0, `div_busy_o` = 0, `div_rd_o` = 0). The state goes to IDLE and the counter to 0 at the edge.
- Reset asserted mid-divide aborts the entry. A `div_ready_i` arriving after reset is ignored.
- Simultaneous `ex_div_start_i` and jump in IDLE: the entry is still latched, since the divide is already in EX.

## Configuration
- `HAZARD_LOAD_USE_EN` defined: `load_haz` is generated and load-use inserts a 1-cycle bubble.
- `HAZARD_LOAD_USE_EN` undefined: `load_haz` is tied to 0. This is for builds where the load result is forwarded in time, and load-dependent instructions issue back-to-back with no stall.

## Test plan
- Divide dependency: `ex_div_start_i`, rd=5, then decode reads rs1=5 with `div_ready_i` 10 cycles later. Required: `hold_o` = 111 for all 11 cycles including DIV_WB, 000 next, `stall_cnt_o` = 11.
- Independent work and second divide: during DIV_WAIT, decode rs1=6 gives `hold_o` = 000. A second divide (`id_is_div_i`) gives `hold_o` = 111 until after DIV_WB. Decode rd=5 (WAW) gives `hold_o` = 111.
- x0 and load-use: divide rd=0 gives `div_busy_o` = 1 but rs1=0 is not held. With the macro, load rd=3 plus decode rs2=3 gives one cycle of 111. Without the macro it gives 000.
- Priority: jump + `div_haz` + `bus_hold_i` in the same cycle gives `flush_o` = 1 and `hold_o` = 000. `bus_hold_i` alone gives 111 and `flush_o` = 0.
- Reset mid-divide: `rst` high in DIV_WAIT gives `div_busy_o` = 0 and `div_rd_o` = 0 the next cycle. A later stray `div_ready_i` causes no state change and the counter is 0.
- Counter saturation: preload near all-ones with `CNT_W` = 4 and hold for 20 cycles. Required: `stall_cnt_o` stays at 4'hF.
